// File: rtl/debug_led_pkg.sv
// Shared definitions for the Wishbone debug LED block: register word
// indices, channel mode encodings, version and a byte-lane mask helper.
package debug_led_pkg;

  // Word indices (byte address bits [5:2])
  localparam logic [3:0] REG_LED_VAL     = 4'h0;
  localparam logic [3:0] REG_LED_MODE    = 4'h1;
  localparam logic [3:0] REG_PRESCALE    = 4'h2;
  localparam logic [3:0] REG_INFO        = 4'h3;
  localparam logic [3:0] REG_CH_CFG_BASE = 4'h4;

  localparam logic [7:0] VERSION = 8'h02;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_RSVD   = 2'b11
  } led_mode_e;

  // Expand the four byte-lane enables into a 32-bit bit mask
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/debug_led_chan.sv
// One LED channel: blink half-period counter and phase, mode mux and the
// registered (optionally inverted) pin output.
module debug_led_chan
  import debug_led_pkg::*;
#(
  parameter logic RESET_LVL  = 1'b1,
  parameter logic ACTIVE_LOW = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic [7:0] i_pwm_cnt,
  input  logic [1:0] i_mode,
  input  logic [15:0] i_cfg,
  input  logic       i_static,
  input  logic       i_mode_wr,
  input  logic [1:0] i_mode_wdata,
  output logic       o_led
);

  logic [7:0] r_blink_cnt;
  logic       r_phase;
  logic       r_led;
  logic       w_enter;
  logic       w_mux;
  logic [7:0] w_duty;
  logic [7:0] w_half;

  assign w_duty  = i_cfg[7:0];
  assign w_half  = i_cfg[15:8];
  // A mode write that switches this channel into blink from another mode
  assign w_enter = i_mode_wr && (i_mode_wdata == MODE_BLINK) && (i_mode != MODE_BLINK);

  // Blink counter: HALF+1 ticks per half-period, phase restarts high on entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (w_enter) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if ((i_mode == MODE_BLINK) && i_tick) begin
      if (r_blink_cnt == w_half) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 8'd1;
      end
    end
  end

  // Mode mux; reserved mode falls back to static
  always_comb begin
    w_mux = i_static;
    case (i_mode)
      MODE_BLINK: w_mux = r_phase;
      MODE_PWM:   w_mux = (i_pwm_cnt < w_duty);
      default:    w_mux = i_static;
    endcase
  end

  // Registered pin, polarity applied after the mux
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_led <= RESET_LVL;
    else          r_led <= w_mux ^ ACTIVE_LOW;
  end

  assign o_led = r_led;

endmodule

// File: rtl/debug_led_wb.sv
// Wishbone slave driving N_LEDS debug LEDs in static, blink or PWM mode.
// Holds bus decode, register file, shared prescaler and PWM counter.
module debug_led_wb
  import debug_led_pkg::*;
#(
  parameter int                N_LEDS     = 4,
  parameter int                PRESC_W    = 24,
  parameter logic [N_LEDS-1:0] LED_RESET  = {N_LEDS{1'b1}},
  parameter logic              ACTIVE_LOW = 1'b0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic [N_LEDS-1:0] led
);

  logic                r_ack;
  logic [31:0]         r_dat;
  logic [N_LEDS-1:0]   r_led_val;
  logic [2*N_LEDS-1:0] r_led_mode;
  logic [PRESC_W-1:0]  r_presc;
  logic [PRESC_W-1:0]  r_presc_cnt;
  logic [7:0]          r_pwm_cnt;
  logic [15:0]         r_cfg [N_LEDS];

  logic                w_access;
  logic                w_wr;
  logic [3:0]          w_idx;
  logic [31:0]         w_bmask;
  logic [31:0]         w_rdata;
  logic                w_tick;
  logic                w_mode_wr;
  logic [N_LEDS-1:0]   w_val_w;
  logic [2*N_LEDS-1:0] w_mode_w;
  logic [PRESC_W-1:0]  w_presc_w;
  logic [15:0]         w_cfg_w [N_LEDS];
  logic                w_unused_bits;

  // New access only when no ack is in flight, so a held strobe acks every other cycle
  assign w_access  = wb_cyc_i && wb_stb_i && !r_ack;
  assign w_wr      = w_access && wb_we_i;
  assign w_idx     = wb_adr_i[5:2];
  assign w_bmask   = byte_mask(wb_sel_i);
  assign w_mode_wr = w_wr && (w_idx == REG_LED_MODE);
  assign w_tick    = (r_presc_cnt == r_presc);

  assign w_val_w   = (r_led_val  & ~w_bmask[N_LEDS-1:0])   | (wb_dat_i[N_LEDS-1:0]   & w_bmask[N_LEDS-1:0]);
  assign w_mode_w  = (r_led_mode & ~w_bmask[2*N_LEDS-1:0]) | (wb_dat_i[2*N_LEDS-1:0] & w_bmask[2*N_LEDS-1:0]);
  assign w_presc_w = (r_presc    & ~w_bmask[PRESC_W-1:0])  | (wb_dat_i[PRESC_W-1:0]  & w_bmask[PRESC_W-1:0]);

  assign w_unused_bits = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, w_bmask};

  // Read mux; unmapped words and unimplemented bits read as zero
  always_comb begin
    w_rdata = '0;
    if (w_idx == REG_LED_VAL)       w_rdata[N_LEDS-1:0]   = r_led_val;
    else if (w_idx == REG_LED_MODE) w_rdata[2*N_LEDS-1:0] = r_led_mode;
    else if (w_idx == REG_PRESCALE) w_rdata[PRESC_W-1:0]  = r_presc;
    else if (w_idx == REG_INFO)     w_rdata = {16'h0, VERSION, 8'(N_LEDS)};
    else begin
      for (int i = 0; i < N_LEDS; i++)
        if (w_idx == REG_CH_CFG_BASE + 4'(i)) w_rdata[15:0] = r_cfg[i];
    end
  end

  // Single-cycle ack with registered read data
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_access;
      r_dat <= w_access ? w_rdata : '0;
    end
  end

  // Register writes land on the same edge that raises ack
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_led_val  <= LED_RESET;
      r_led_mode <= '0;
      r_presc    <= '0;
      for (int i = 0; i < N_LEDS; i++) r_cfg[i] <= '0;
    end else if (w_wr) begin
      if (w_idx == REG_LED_VAL)  r_led_val  <= w_val_w;
      if (w_idx == REG_LED_MODE) r_led_mode <= w_mode_w;
      if (w_idx == REG_PRESCALE) r_presc    <= w_presc_w;
      for (int i = 0; i < N_LEDS; i++)
        if (w_idx == REG_CH_CFG_BASE + 4'(i)) r_cfg[i] <= w_cfg_w[i];
    end
  end

  // Prescaler 0..PRESCALE; a count beyond a freshly lowered limit restarts at 0
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                r_presc_cnt <= '0;
    else if (r_presc_cnt >= r_presc) r_presc_cnt <= '0;
    else                           r_presc_cnt <= r_presc_cnt + 1'b1;
  end

  // Free-running PWM counter, wraps 255 -> 0
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_pwm_cnt <= '0;
    else            r_pwm_cnt <= r_pwm_cnt + 8'd1;
  end

  generate
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_chan
      assign w_cfg_w[gi] = (r_cfg[gi] & ~w_bmask[15:0]) | (wb_dat_i[15:0] & w_bmask[15:0]);

      debug_led_chan #(
        .RESET_LVL  (LED_RESET[gi] ^ ACTIVE_LOW),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_chan (
        .i_clk        (wb_clk_i),
        .i_rst_n      (wb_rst_ni),
        .i_tick       (w_tick),
        .i_pwm_cnt    (r_pwm_cnt),
        .i_mode       (r_led_mode[2*gi +: 2]),
        .i_cfg        (r_cfg[gi]),
        .i_static     (r_led_val[gi]),
        .i_mode_wr    (w_mode_wr),
        .i_mode_wdata (w_mode_w[2*gi +: 2]),
        .o_led        (led[gi])
      );
    end
  endgenerate

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;

endmodule
